// File: rtl/ltf_channel_estimator.sv
// L-LTF channel estimator: averages the two FFT'd LTF symbols bin by bin and
// removes the known BPSK pattern, emitting 52 CSI beats (nulls/DC dropped).

module ltf_demod_lane #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                neg,
  output logic signed [W-1:0] y
);
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAXV = ~MINV;

  logic signed [W:0]   s;
  logic signed [W-1:0] avg;

  always_comb begin
    s   = {a[W-1], a} + {b[W-1], b};
    avg = s[W:1];  // floor(s/2)
    if (!neg)              y = avg;
    else if (avg == MINV)  y = MAXV;  // -(-2^(W-1)) does not fit
    else                   y = -avg;
  end
endmodule

module ltf_channel_estimator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         fft_axis_tvalid,
  input  logic                         fft_axis_tlast,
  input  logic signed [DATA_WIDTH-1:0] fft_re_axis_tdata,
  input  logic signed [DATA_WIDTH-1:0] fft_im_axis_tdata,
  output logic                         fft_axis_tready,
  output logic                         csi_axis_tvalid,
  output logic                         csi_axis_tlast,
  output logic signed [DATA_WIDTH-1:0] csi_re_axis_tdata,
  output logic signed [DATA_WIDTH-1:0] csi_im_axis_tdata,
  output logic [5:0]                   csi_axis_tuser,
  input  logic                         csi_axis_tready,
  output logic                         frame_err
);
  localparam int NUM_LANES = 2;  // lane 1 = re, lane 0 = im

  typedef enum logic {COLLECT_A, COLLECT_B} state_t;

  typedef struct packed {
    logic                                 last;
    logic [5:0]                           bin;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] iq;
  } csi_beat_t;

  state_t    state_q, state_d;
  logic [5:0] k_q, k_d;
  logic      accept, at_end, err, load, ltf_neg;
  logic      out_vld_q;
  csi_beat_t out_q;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_iq, a_iq, y_iq;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] buf_mem [64];

  function automatic logic ltf_null(input logic [5:0] k);
    return (k == 6'd0) || (k >= 6'd27 && k <= 6'd37);
  endfunction

  function automatic logic ltf_is_neg(input logic [5:0] k);
    case (k)
      6'd2, 6'd3, 6'd6, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
      6'd17, 6'd18, 6'd20, 6'd22,
      6'd40, 6'd41, 6'd44, 6'd46, 6'd53, 6'd54, 6'd57, 6'd59: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign in_iq   = {fft_re_axis_tdata, fft_im_axis_tdata};
  assign a_iq    = buf_mem[k_q];
  assign ltf_neg = ltf_is_neg(k_q);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ltf_demod_lane #(.W(DATA_WIDTH)) u_lane (
      .a   (a_iq[i]),
      .b   (in_iq[i]),
      .neg (ltf_neg),
      .y   (y_iq[i])
    );
  end

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    fft_axis_tready = 1'b1;
    // single output register: B accepts only when it can be refilled
    if (state_q == COLLECT_B) fft_axis_tready = !out_vld_q || csi_axis_tready;
    accept = fft_axis_tvalid && fft_axis_tready;
    at_end = (k_q == 6'd63);
    err    = accept && (fft_axis_tlast != at_end);
    if (accept) begin
      k_d = err ? 6'd0 : k_q + 6'd1;
      if (err)         state_d = COLLECT_A;
      else if (at_end) state_d = (state_q == COLLECT_A) ? COLLECT_B : COLLECT_A;
    end
    load = accept && (state_q == COLLECT_B) && !err && !ltf_null(k_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= COLLECT_A;
      k_q       <= '0;
      frame_err <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      frame_err <= err;
      if (load) begin
        out_vld_q <= 1'b1;
        out_q     <= '{last: at_end, bin: k_q, iq: y_iq};
      end else if (out_vld_q && csi_axis_tready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  // buffer contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk_in) begin
    if (accept && state_q == COLLECT_A) buf_mem[k_q] <= in_iq;
  end

  assign csi_axis_tvalid   = out_vld_q;
  assign csi_axis_tlast    = out_q.last;
  assign csi_axis_tuser    = out_q.bin;
  assign csi_re_axis_tdata = out_q.iq[1];
  assign csi_im_axis_tdata = out_q.iq[0];
endmodule

// File: doc/ltf_channel_estimator.md
# ltf_channel_estimator

Downstream consumer of the 64-point block FFT in the CSI extractor. It takes the two back-to-back 802.11a/g L-LTF symbols, already FFT'd and framed by `tlast`, and averages them bin by bin. It removes the known LTF BPSK pattern and emits one 52-entry CSI vector per packet on an AXI-Stream output. Null and DC bins are dropped; each output beat carries its FFT bin index.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each re/im component on input and output.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `fft_axis_tvalid`  in  1  FFT bin valid.
- `fft_axis_tlast`  in  1  marks bin 63 of a symbol.
- `fft_re_axis_tdata`, `fft_im_axis_tdata`  in  DATA_WIDTH (signed)  bin value, FFT order 0..63.
- `fft_axis_tready`  out  1  accepts bin.
- `csi_axis_tvalid`  out  1  CSI beat valid.
- `csi_axis_tlast`  out  1  marks last CSI beat of the vector (bin 63).
- `csi_re_axis_tdata`, `csi_im_axis_tdata`  out  DATA_WIDTH (signed)  channel estimate.
- `csi_axis_tuser`  out  6  FFT bin index of the beat.
- `csi_axis_tready`  in  1  downstream accepts.
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- Bin counter `k` (6 bit) counts accepted input beats.
  - It resets to 0 after bin 63 and after an error.
- States: `COLLECT_A`, `COLLECT_B`.
- **`COLLECT_A`**
  - `fft_axis_tready` = 1.
  - Each accepted beat writes {re, im} to a 64×(2·DATA_WIDTH) buffer at address `k`.
  - If `tlast` arrives with k==63: go to `COLLECT_B`.
- **`COLLECT_B`**
  - `fft_axis_tready` = !`csi_axis_tvalid` || `csi_axis_tready` (single output register, no skid).
  - Each accepted beat reads A[k] asynchronously from the buffer.
  - Computes s = (A[k] + B[k]) as DATA_WIDTH+1 bits, then avg = s >>> 1 (arithmetic shift, floor), per component.
  - Looks up L[k] from a constant table:
    - L = 0 for k ∈ {0, 27..37}.
    - L[1..26] = + − − + + − + − + − − − − − + + − − + − + − + + + +.
    - L[38..63] = + + − − + + − + − + + + + + + − − + + − + − + + + +.
  - L=+1: out = avg. L=−1: out = −avg, with −(−2^(DATA_WIDTH−1)) saturated to 2^(DATA_WIDTH−1)−1.
  - L=0: beat is consumed but no output is produced.
  - k==63 with `tlast`: the output beat carries `csi_axis_tlast`=1, then the state returns to `COLLECT_A`.
- **Framing error**: `tlast` with k≠63, or k==63 without `tlast`, in either state.
  - Pulse `frame_err`, set k=0, go to `COLLECT_A`.
  - The partial vector is abandoned. `csi_axis_tlast` is not forced; downstream relies on the `frame_err` pulse.
- Exactly 52 output beats per good packet, `tuser` ascending 1..26 then 38..63.
- Reset mid-operation: state `COLLECT_A`, k=0, output register cleared. Buffer contents are don't-care.

## Timing
- Reset values:
  - `csi_axis_tvalid`=0, `csi_axis_tlast`=0, `csi_re/im`=0, `csi_axis_tuser`=0.
  - `frame_err`=0, `fft_axis_tready`=1 (state `COLLECT_A`).
- Latency: an input beat accepted at edge t in `COLLECT_B` appears on `csi_*` after edge t (valid in cycle t+1).
- Output beat holds stable while `csi_axis_tvalid` && !`csi_axis_tready`.
- Throughput: 1 bin/cycle in both states when downstream is always ready.
- Simultaneous output handshake and new input accept in the same cycle: the register reloads with no bubble.
- A zero-bin accept with an output handshake: `csi_axis_tvalid` drops to 0 next cycle.
- `frame_err` is asserted the cycle after the offending accept.
- The first A beat of the next packet may be accepted in the cycle after the last B accept. The final CSI beat may still be pending; `COLLECT_A` does not touch the output register.

## Test plan
- **Basic path.** A = B = all bins (re=1000, im=−200), `csi_axis_tready`=1.
  - Required: 52 beats.
  - Bin 1: (1000, −200). Bin 2: (−1000, 200). Bin 38: (1000, −200).
  - `tlast` only on tuser=63. No beats for bins 0 and 27..37.
- **Averaging and floor.** A[5] = (3, −3), B[5] = (0, 0); L[5]=+1.
  - Required: bin 5 output = (1, −2).
- **Saturation.** A[2] = B[2] = (−32768, 32767); L[2]=−1.
  - Required: (32767, −32767).
- **Backpressure.** Random `csi_axis_tready` (~50%) during symbol B.
  - Required: no lost or duplicated beats.
  - Data held stable while stalled.
  - `fft_axis_tready` low only while output is full and not ready.
- **Framing error.** `tlast` on the 40th beat of symbol A.
  - Required: `frame_err` pulse, no output.
  - Two following good symbols produce a correct 52-beat vector.
- **Reset mid-symbol B.** After 20 B beats, assert reset for 1 cycle.
  - Required: outputs return to reset values, the partial vector is discarded, and the next packet is processed correctly.
